// File: rtl/idct_pkg.sv
// Shared constants, Q14 basis matrix, FSM states and
// rounding/saturation helpers for the 8x8 inverse DCT.
package idct_pkg;

    localparam int IN_W   = 12;
    localparam int COEF_W = 16;
    localparam int FRAC   = 14;
    localparam int MID_W  = 16;
    localparam int RES_W  = 40;

    typedef enum logic [1:0] {
        LOAD,
        ROW,
        COL,
        OUT
    } state_e;

    // A[k*8+n] = c_k * cos((2n+1)k*pi/16) in Q1.14
    localparam logic signed [COEF_W-1:0] A_COEF [64] = '{
         16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,
         16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,
         16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598,
        -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035,
         16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568,
        -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568,
         16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,
         16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811,
         16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,
         16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,
         16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811,
        -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551,
         16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135,
        -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135,
         16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,
         16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598
    };

    localparam logic signed [RES_W-1:0] MID_MAX =
        RES_W'((2 ** (MID_W - 1)) - 1);
    localparam logic signed [RES_W-1:0] MID_MIN =
        -MID_MAX - RES_W'(1);

    function automatic logic signed [MID_W-1:0] sat_mid(
        input logic signed [RES_W-1:0] v
    );
        logic signed [RES_W-1:0] s;
        s = v;
        if (v > MID_MAX) s = MID_MAX;
        if (v < MID_MIN) s = MID_MIN;
        return s[MID_W-1:0];
    endfunction

    function automatic logic [7:0] clamp_pix(
        input logic signed [RES_W-1:0] v
    );
        logic signed [RES_W-1:0] s;
        logic [7:0] p;
        s = v + RES_W'(128);
        p = s[7:0];
        if (s < 0) p = 8'd0;
        if (s > RES_W'(255)) p = 8'd255;
        return p;
    endfunction

endpackage

// File: rtl/idct_dot8.sv
// Combinational 8-term signed dot product with
// round-half-up shift by FRAC bits.
module idct_dot8
    import idct_pkg::*;
#(
    parameter int DW = IN_W
) (
    input  logic signed [COEF_W-1:0] a_i [8],
    input  logic signed [DW-1:0]     d_i [8],
    output logic signed [RES_W-1:0]  res_o
);

    localparam int PW = COEF_W + DW;
    localparam int SW = PW + 3;
    localparam logic signed [SW-1:0] HALF =
        {{(SW - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};

    logic signed [PW-1:0] prod [8];
    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] rnd;

    always_comb begin
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            prod[k] = PW'(a_i[k]) * PW'(d_i[k]);
            acc = acc + SW'(prod[k]);
        end
        rnd = (acc + HALF) >>> FRAC;
        res_o = RES_W'(rnd);
    end

endmodule

// File: rtl/idct_8x8.sv
// Single-buffered 8x8 inverse DCT: load 64 coefficients,
// row pass, column pass, then stream 64 pixels.
module idct_8x8
    import idct_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   busy
);

    state_e state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic in_ready_q, in_ready_d;
    logic out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;

    logic signed [IN_W-1:0] ybuf_q [64];
    logic signed [MID_W-1:0] tbuf_q [64];
    logic [7:0] xbuf_q [64];

    logic in_hs, out_hs;
    logic signed [COEF_W-1:0] row_a [8];
    logic signed [COEF_W-1:0] col_a [8];
    logic signed [IN_W-1:0] row_d [8];
    logic signed [MID_W-1:0] col_d [8];
    logic signed [RES_W-1:0] row_res, col_res;

    assign in_hs = in_valid & in_ready_q;
    assign out_hs = out_valid_q & out_ready;

    // cnt_q = i*8+j during the passes
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            row_a[k] = A_COEF[{3'(k), cnt_q[5:3]}];
            row_d[k] = ybuf_q[{3'(k), cnt_q[2:0]}];
            col_a[k] = A_COEF[{3'(k), cnt_q[2:0]}];
            col_d[k] = tbuf_q[{cnt_q[5:3], 3'(k)}];
        end
    end

    idct_dot8 #(.DW(IN_W)) u_row (
        .a_i   (row_a),
        .d_i   (row_d),
        .res_o (row_res)
    );

    idct_dot8 #(.DW(MID_W)) u_col (
        .a_i   (col_a),
        .d_i   (col_d),
        .res_o (col_res)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        unique case (state_q)
            LOAD: begin
                if (in_hs) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) state_d = ROW;
                end
            end
            ROW: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) state_d = COL;
            end
            COL: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) state_d = OUT;
            end
            OUT: begin
                if (out_hs) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // pixel register follows cnt_d so it is stable while stalled
    always_comb begin
        in_ready_d = (state_d == LOAD);
        out_valid_d = (state_d == OUT);
        out_data_d = out_data_q;
        if (out_valid_d) out_data_d = xbuf_q[cnt_d];
    end

    always_ff @(posedge clk) begin
        if (state_q == LOAD && in_hs) ybuf_q[cnt_q] <= in_data;
        if (state_q == ROW) tbuf_q[cnt_q] <= sat_mid(row_res);
        if (state_q == COL) xbuf_q[cnt_q] <= clamp_pix(col_res);
    end

    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign busy = !(state_q == LOAD && cnt_q == 6'd0);

endmodule

// File: tb/tb_idct_8x8.sv
// Randomised and directed bench for idct_8x8 against a
// floating-point-derived Q14 reference of X = A^T*Y*A.
module tb_idct_8x8;

    logic clk = 1'b0;
    logic rstn;
    logic in_valid;
    logic in_ready;
    logic signed [11:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [7:0] out_data;
    logic busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int rdy_pct = 100;

    longint amat [8][8];
    int ymod [64];
    int expv [64];

    idct_8x8 dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void build_a();
        real c, v;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                c = (k == 0) ? $sqrt(0.125) : 0.5;
                v = c * $cos((2 * n + 1) * k * 3.14159265358979 / 16.0);
                v = v * 16384.0;
                amat[k][n] = longint'($rtoi(v + ((v >= 0.0) ? 0.5 : -0.5)));
            end
        end
    endfunction

    function automatic longint rnd14(input longint s);
        return (s + 64'sd8192) >>> 14;
    endfunction

    function automatic void model();
        longint t [8][8];
        longint s;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++)
                    s += amat[k][i] * longint'(ymod[k * 8 + j]);
                s = rnd14(s);
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                t[i][j] = s;
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += t[i][k] * amat[k][j];
                s = rnd14(s) + 128;
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                expv[i * 8 + j] = int'(s);
            end
        end
    endfunction

    function automatic int srand(input int m);
        return int'($urandom_range(0, 2 * m)) - m;
    endfunction

    function automatic void rand_block(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0: ymod[i] = (i == 0) ? srand(1023) :
                             (($urandom_range(0, 1) == 1) ? srand(63) : 0);
                1: ymod[i] = srand(2047);
                default: ymod[i] = srand(300);
            endcase
        end
    endfunction

    function automatic void dc_block(input int dc, input int pix);
        for (int i = 0; i < 64; i++) begin
            ymod[i] = 0;
            expv[i] = pix;
        end
        ymod[0] = dc;
    endfunction

    task automatic send_block();
        int i = 0;
        int g = 0;
        bit acc;
        while (i < 64 && g < 1000) begin
            in_valid = ($urandom_range(0, 99) < 80);
            in_data = 12'(ymod[i]);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            g++;
            if (acc) begin
                i++;
                last_acc = cyc;
            end
        end
        in_valid = 1'b0;
        chk("load_beats", 32'(i), 64);
    endtask

    // out_valid must appear 128 edges after the final accept edge
    task automatic wait_valid();
        int g = 0;
        while (out_valid !== 1'b1 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("latency", 32'(cyc - last_acc), 128);
        chk("busy_out", 32'(busy), 1);
    endtask

    task automatic recv(input int nbeats);
        int b = 0;
        int g = 0;
        bit stalled = 1'b0;
        logic [7:0] held = '0;
        while (b < nbeats && g < 5000) begin
            if (stalled) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(held));
            end
            stalled = 1'b0;
            if (out_valid) begin
                chk("in_ready_out", 32'(in_ready), 0);
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                if (out_ready) begin
                    chk($sformatf("pix%0d", b), 32'(out_data), expv[b]);
                    b++;
                end else begin
                    stalled = 1'b1;
                    held = out_data;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data = 12'($urandom);
            @(posedge clk);
            #1;
            g++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("out_beats", 32'(b), 32'(nbeats));
    endtask

    task automatic run_block();
        send_block();
        wait_valid();
        recv(64);
        chk("drop_valid", 32'(out_valid), 0);
        chk("ready_back", 32'(in_ready), 1);
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", 32'(in_ready), 1);
        chk("rel_busy", 32'(busy), 0);
    endtask

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        build_a();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_data", 32'(out_data), 0);
        chk("reset_busy", 32'(busy), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("first_ready", 32'(in_ready), 1);
        chk("idle_busy", 32'(busy), 0);

        dc_block(64, 136);
        run_block();
        dc_block(0, 128);
        run_block();
        dc_block(-1024, 0);
        run_block();
        dc_block(2047, 255);
        run_block();
        dc_block(-2048, 0);
        run_block();

        dc_block(0, 0);
        ymod[1] = 100;
        model();
        rdy_pct = 30;
        run_block();
        rand_block(0);
        model();
        run_block();
        rand_block(2);
        model();
        run_block();

        rdy_pct = 70;
        rand_block(0);
        model();
        send_block();
        repeat (10) @(posedge clk);
        #1;
        pulse_reset();
        rand_block(0);
        model();
        run_block();

        rand_block(2);
        model();
        send_block();
        wait_valid();
        recv(20);
        pulse_reset();
        rand_block(0);
        model();
        run_block();

        for (int n = 0; n < 150; n++) begin
            rdy_pct = int'($urandom_range(50, 100));
            rand_block(n % 3);
            model();
            run_block();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
